vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator: successor to the fixed 640x480@60 sync block. Produces hsync/vsync with per-axis programmable polarity, video_on, raster coordinates, and line/frame start strobes from a single system clock. An optional pixel-rate divider lets the core run directly on a clock faster than the pixel clock. It sits between the board clock and the pixel/renderer logic (snake playfield, sprites) and is the single source of raster position for the display path.

---
 rtl/vga_timing_gen.sv | 116 +++++++++++
 tb/tb_vga_timing_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: programmable porches/sync widths and sync polarity.
// Define VGA_TIMING_CLKDIV_EN to compile in the CLK_DIV clocks-per-pixel divider.
module vga_timing_gen #(
  parameter int   H_DISPLAY = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_DISPLAY = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CNT_W     = 10,
  parameter int   CLK_DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             pix_tick,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS     = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS     = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

  if (CLK_DIV < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("vga_timing_gen: CLK_DIV and CNT_W must be at least 1");
  end

  logic             tick;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

`ifdef VGA_TIMING_CLKDIV_EN
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (enable) begin
      div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

  assign tick = enable && (div == DIV_LAST);
`else
  assign tick = enable;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  logic hs_act;
  logic vs_act;
  logic vis;

  assign hs_act = (h_cnt >= H_SYNC_LO) && (h_cnt < H_SYNC_HI);
  assign vs_act = (v_cnt >= V_SYNC_LO) && (v_cnt < V_SYNC_HI);
  assign vis    = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  // Level outputs only refresh on a pixel advance, so they freeze with enable low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= tick;
      line_start  <= tick && (h_cnt == '0);
      frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
      if (tick) begin
        hsync    <= hs_act ? HSYNC_POL : ~HSYNC_POL;
        vsync    <= vs_act ? VSYNC_POL : ~VSYNC_POL;
        video_on <= vis;
        pixel_x  <= h_cnt;
        pixel_y  <= v_cnt;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing DUT and a tiny positive-polarity DUT
// run in lockstep against a per-clock scoreboard plus raster-level measurements.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_CLKDIV_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  logic       hs0, vs0, vo0, pt0, ls0, fs0;
  logic [9:0] px0, py0;
  logic       hs1, vs1, vo1, pt1, ls1, fs1;
  logic [9:0] px1, py1;

  vga_timing_gen #(.CLK_DIV(DIV)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .hsync(hs0), .vsync(vs0), .video_on(vo0),
    .pixel_x(px0), .pixel_y(py0),
    .pix_tick(pt0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(10), .CLK_DIV(DIV)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .hsync(hs1), .vsync(vs1), .video_on(vo1),
    .pixel_x(px1), .pixel_y(py1),
    .pix_tick(pt1), .line_start(ls1), .frame_start(fs1)
  );

  // {hsync, vsync, video_on, pix_tick, line_start, frame_start, pixel_x, pixel_y}
  logic [25:0] out0, out1;
  assign out0 = {hs0, vs0, vo0, pt0, ls0, fs0, px0, py0};
  assign out1 = {hs1, vs1, vo1, pt1, ls1, fs1, px1, py1};

  int HD[2] = '{640, 8};
  int HF[2] = '{16, 2};
  int HS[2] = '{96, 3};
  int HT[2] = '{800, 14};
  int VD[2] = '{480, 4};
  int VF[2] = '{10, 1};
  int VS[2] = '{2, 1};
  int VT[2] = '{525, 7};
  bit HP[2] = '{1'b0, 1'b1};
  bit VP[2] = '{1'b0, 1'b1};

  int          mh[2], mv[2], mdiv[2];
  logic [25:0] held[2];
  logic [25:0] q0[$];
  logic [25:0] q1[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int last_ls0 = -1, ls_per0 = 0;
  bit hs0_prev = 1'b1;
  int hs0_x = -1, hs0_run = 0, hs0_len = 0;
  int last_fs1 = -1, fs_per1 = 0;
  int vo_acc1 = 0, vo_frame1 = 0;
  bit hs1_prev = 1'b0, vs1_prev = 1'b0;
  int hs1_x = -1, hs1_run = 0, hs1_len = 0;
  int vs1_y = -1, vs1_run = 0, vs1_len = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [25:0] rst_vec(input int i);
    return {!HP[i], !VP[i], 1'b0, 3'b000, 20'd0};
  endfunction

  task automatic model_reset(input int i);
    mh[i]   = 0;
    mv[i]   = 0;
    mdiv[i] = 0;
    held[i] = rst_vec(i);
  endtask

  task automatic model_step(input int i, input bit en, output logic [25:0] e);
    bit tk, hsa, vsa, vis;
    tk = en && (mdiv[i] == DIV - 1);
    if (en) mdiv[i] = (mdiv[i] == DIV - 1) ? 0 : mdiv[i] + 1;
    if (tk) begin
      hsa = (mh[i] >= HD[i] + HF[i]) && (mh[i] < HD[i] + HF[i] + HS[i]);
      vsa = (mv[i] >= VD[i] + VF[i]) && (mv[i] < VD[i] + VF[i] + VS[i]);
      vis = (mh[i] < HD[i]) && (mv[i] < VD[i]);
      held[i] = {hsa ? HP[i] : !HP[i], vsa ? VP[i] : !VP[i], vis, 3'b000,
                 10'(mh[i]), 10'(mv[i])};
      e = held[i];
      e[22] = 1'b1;
      e[21] = (mh[i] == 0);
      e[20] = (mh[i] == 0) && (mv[i] == 0);
      if (mh[i] == HT[i] - 1) begin
        mh[i] = 0;
        mv[i] = (mv[i] == VT[i] - 1) ? 0 : mv[i] + 1;
      end else begin
        mh[i] = mh[i] + 1;
      end
    end else begin
      e = held[i];
    end
  endtask

  task automatic step(input bit en);
    logic [25:0] e;
    enable = en;
    model_step(0, en, e);
    q0.push_back(e);
    model_step(1, en, e);
    q1.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    check("out0", 32'(out0), 32'(q0.pop_front()));
    check("out1", 32'(out1), 32'(q1.pop_front()));

    if (ls0) begin
      if (last_ls0 >= 0) ls_per0 = cyc - last_ls0;
      last_ls0 = cyc;
    end
    if (!hs0 && hs0_prev) begin hs0_x = int'(px0); hs0_run = 0; end
    if (!hs0) hs0_run++;
    if (hs0 && !hs0_prev) hs0_len = hs0_run;
    hs0_prev = hs0;

    if (fs1) begin
      if (last_fs1 >= 0) fs_per1 = cyc - last_fs1;
      last_fs1 = cyc;
      vo_frame1 = vo_acc1;
      vo_acc1 = 0;
    end
    if (vo1 && pt1) vo_acc1++;
    if (hs1 && !hs1_prev) begin hs1_x = int'(px1); hs1_run = 0; end
    if (hs1) hs1_run++;
    if (!hs1 && hs1_prev) hs1_len = hs1_run;
    hs1_prev = hs1;
    if (vs1 && !vs1_prev) begin vs1_y = int'(py1); vs1_run = 0; end
    if (vs1) vs1_run++;
    if (!vs1 && vs1_prev) vs1_len = vs1_run;
    vs1_prev = vs1;
  endtask

  // sel 0: next pix_tick on dut0 (at pixel_x == px when px >= 0); sel 1: next line_start on dut0
  task automatic run_until(input int sel, input int px, input int budget, output int n);
    bit hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < budget) begin
      step(1'b1);
      n++;
      hit = (sel == 0) ? (pt0 && (px < 0 || int'(px0) == px)) : ls0;
    end
    check("wait_event", 32'(hit), 32'd1);
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out0", 32'(out0), 32'(rst_vec(0)));
    check("rst_out1", 32'(out1), 32'(rst_vec(1)));
    model_reset(0);
    model_reset(1);

    @(negedge clk);
    rst_n = 1'b1;
    run_until(0, -1, 4 * DIV, n);
    check("first_latency", 32'(n), 32'(DIV));
    check("first_xy", {px0, py0}, 20'd0);
    check("first_strobes", {vo0, ls0, fs0}, 3'b111);

    repeat (3 * 800 * DIV) step(1'b1);
    check("line_period", 32'(ls_per0), 32'(800 * DIV));
    check("hsync_start_x", 32'(hs0_x), 32'd656);
    check("hsync_len", 32'(hs0_len), 32'(96 * DIV));
    check("tiny_frame_period", 32'(fs_per1), 32'(98 * DIV));
    check("tiny_video_pixels", 32'(vo_frame1), 32'd32);
    check("tiny_hsync_x", 32'(hs1_x), 32'd10);
    check("tiny_hsync_len", 32'(hs1_len), 32'(3 * DIV));
    check("tiny_vsync_y", 32'(vs1_y), 32'd5);
    check("tiny_vsync_len", 32'(vs1_len), 32'(14 * DIV));

    run_until(0, 300, 900 * DIV, n);
    repeat (37) step(1'b0);
    check("hold_x", 32'(px0), 32'd300);
    check("hold_strobes", {pt0, ls0, fs0}, 3'b000);
    run_until(0, -1, 2 * DIV, n);
    check("resume_x", 32'(px0), 32'd301);
    run_until(1, -1, 900 * DIV, n);
    check("stretched_line", 32'(ls_per0), 32'(800 * DIV + 37));

    run_until(0, 500, 900 * DIV, n);
    rst_n = 1'b0;
    #1;
    check("async_rst0", 32'(out0), 32'(rst_vec(0)));
    check("async_rst1", 32'(out1), 32'(rst_vec(1)));
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    #1;
    check("rst_hold0", 32'(out0), 32'(rst_vec(0)));
    @(negedge clk);
    rst_n = 1'b1;
    run_until(0, -1, 4 * DIV, n);
    check("restart_latency", 32'(n), 32'(DIV));
    check("restart_xy", {px0, py0}, 20'd0);
    check("restart_frame", 32'(fs0), 32'd1);

    repeat (200) step(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
